twin_status_reporter: RTL and testbench
=======================================

Name: twin_status_reporter

Overview:
- Upstream of the UART transmitter in the 50 MHz twin-link domain.
- Takes the already-synchronised virtual LED/SEG state from the CPU domain and serialises it into checksummed status frames, one byte at a time, over the UART tx handshake (tx_start / tx_data / tx_busy).
- Sends a frame when the state changes, when the periodic refresh timer expires, or on a forced request.

Parameters:
- CLK_FREQ, 50000000, i_clk_50m frequency in Hz.
- REFRESH_MS, 100, maximum interval between frames in ms; REFRESH_CYCLES = CLK_FREQ/1000*REFRESH_MS.
- HEADER, 8'hA5, frame start byte.
- BUSY_WAIT_MAX, 4, cycles allowed for tx_busy to rise after tx_start.

Ports:
- i_clk_50m  in  1  clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- led_in  in  32  synchronised virtual LED state.
- seg_in  in  40  synchronised virtual seven-segment state.
- force_report  in  1  single-cycle request for an immediate frame.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  single-cycle byte send strobe.
- tx_data  out  8  byte to transmit; valid while tx_start=1 and held until the next byte.
- report_busy  out  1  high while a frame is in progress.
- frames_sent  out  16  count of completed frames; wraps 16'hFFFF to 0.

Behaviour:
- Reset values: tx_start=0, tx_data=0, report_busy=0, frames_sent=0, last-sent snapshot=0, refresh counter=0, pending_force=0, state=IDLE.
- Frame, 12 bytes, in order:
  - HEADER
  - type 8'h01
  - led[31:24], led[23:16], led[15:8], led[7:0]
  - seg[39:32], seg[31:24], seg[23:16], seg[15:8], seg[7:0]
  - CHK = XOR of bytes 1..10 (the header is excluded).
- Refresh counter: increments every cycle while in IDLE; saturates at REFRESH_CYCLES-1; clears when a frame starts.
- force_report is latched into pending_force in any state. It clears when a frame starts.
- IDLE trigger: any of
  - {led_in, seg_in} != last-sent snapshot
  - refresh counter == REFRESH_CYCLES-1
  - pending_force
- On a trigger in IDLE at cycle N:
  - capture led_in/seg_in into the frame buffer and the last-sent snapshot
  - precompute CHK
  - set report_busy=1 from cycle N+1
  - go to SEND with idx=0
  - Input changes during a frame do not alter the frame in flight; they re-trigger in IDLE afterwards.
- SEND: if tx_busy==0, drive tx_start=1 for exactly one cycle with tx_data=byte[idx], then go to WAIT_HI. If tx_busy==1, stay (tx_start=0).
- WAIT_HI: on tx_busy==1 go to WAIT_LO. After BUSY_WAIT_MAX cycles without tx_busy, go to WAIT_LO anyway.
- WAIT_LO: on tx_busy==0:
  - if idx==11: frames_sent++, report_busy=0 on the next cycle, go to IDLE
  - else: idx++, go to SEND
- Minimum latency: trigger at cycle N → first tx_start at N+1 if tx_busy==0.
- tx_start is never high on two consecutive cycles and never high while tx_busy==1.
- Simultaneous triggers produce one frame.
- Reset mid-frame: outputs return to reset values immediately and the frame is abandoned. The next frame starts from the header, with no partial resume.

Optional Feature:
- Macro: TWIN_REPORT_SEQ_EN.
- Defined:
  - A sequence byte is inserted after the type byte; the frame is 13 bytes and the last idx is 12.
  - The sequence byte is an 8-bit counter, reset to 0, incremented per completed frame, wrapping 8'hFF→0.
  - CHK covers type, seq and data bytes.
- Undefined: 12-byte frame exactly as above; no sequence register.

Test Plan:
- Reset release, led_in=0, seg_in=0, REFRESH_MS overridden to 1 → first frame at cycle 50000 after reset: A5 01 00 00 00 00 00 00 00 00 00 01; frames_sent=1.
- led_in changes to 32'h12345678, seg_in=40'h0 → frame A5 01 12 34 56 78 00 00 00 00 00 09 within 1 cycle of IDLE; refresh counter cleared.
- led_in toggles to 32'hFFFFFFFF during byte 3 of a frame → current frame carries the old value; a second frame with FF FF FF FF follows; frames_sent increments by 2.
- force_report pulses while report_busy=1 → exactly one extra frame after the current one. Two force pulses in the same frame still give one extra frame.
- UART model that never raises tx_busy → each byte advances after BUSY_WAIT_MAX cycles; the frame completes; tx_start is never asserted on consecutive cycles.
- rst_n low at byte 6 → tx_start=0, report_busy=0, frames_sent=0 asynchronously. After release, the next tx_data is A5.

Source files
------------

// File: rtl/twin_status_reporter_if.sv
// UART transmit byte handshake between the status reporter (master) and the transmitter (slave).
`timescale 1ns/1ps
interface twin_status_reporter_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/twin_status_reporter.sv
// Serialises LED/SEG state into checksummed status frames over the UART byte handshake.
// Optional sequence byte after the type byte when TWIN_REPORT_SEQ_EN is defined.
`timescale 1ns/1ps
module twin_status_reporter #(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned REFRESH_MS    = 100,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int unsigned BUSY_WAIT_MAX = 4
) (
  input  logic                          i_clk_50m,
  input  logic                          rst_n,
  input  logic [31:0]                   led_in,
  input  logic [39:0]                   seg_in,
  input  logic                          force_report,
  twin_status_reporter_if.master        uart,
  output logic                          report_busy,
  output logic [15:0]                   frames_sent
);

  localparam int unsigned REFRESH_CYCLES = CLK_FREQ / 1000 * REFRESH_MS;
  localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam int unsigned WW = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(BUSY_WAIT_MAX - 1);
`ifdef TWIN_REPORT_SEQ_EN
  localparam int unsigned FRAME_LEN = 13;
`else
  localparam int unsigned FRAME_LEN = 12;
`endif
  localparam int unsigned DOFS     = FRAME_LEN - 10;
  localparam logic [3:0]  LAST_IDX = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;
  state_t state, state_n;

  logic [31:0]   snap_led;
  logic [39:0]   snap_seg;
  logic [7:0]    chk, cap_chk;
  logic [3:0]    idx, next_idx;
  logic [WW-1:0] wait_cnt;
  logic [RW-1:0] refresh_cnt;
  logic          pending_force;
  logic [7:0]    tx_data_q;
  logic [7:0]    next_byte;
  logic [7:0]    frame_byte [FRAME_LEN];
  logic          trigger, frame_start, byte_done, frame_done, tx_start_c;
`ifdef TWIN_REPORT_SEQ_EN
  logic [7:0]    seq_cnt, seq_q;
`endif

  assign uart.tx_start = tx_start_c;
  assign uart.tx_data  = tx_data_q;
  assign next_idx      = idx + 4'd1;

  // Frame image built from the captured snapshot; byte 0 is loaded directly at frame start.
  always_comb begin
    for (int unsigned i = 0; i < FRAME_LEN; i++) frame_byte[i] = '0;
    frame_byte[0] = HEADER;
    frame_byte[1] = 8'h01;
`ifdef TWIN_REPORT_SEQ_EN
    frame_byte[2] = seq_q;
`endif
    for (int unsigned i = 0; i < 4; i++) frame_byte[DOFS + i]     = snap_led[31 - 8*i -: 8];
    for (int unsigned i = 0; i < 5; i++) frame_byte[DOFS + 4 + i] = snap_seg[39 - 8*i -: 8];
    frame_byte[FRAME_LEN - 1] = chk;
    next_byte = '0;
    for (int unsigned i = 0; i < FRAME_LEN; i++)
      if (next_idx == 4'(i)) next_byte = frame_byte[i];
  end

  always_comb begin
`ifdef TWIN_REPORT_SEQ_EN
    cap_chk = 8'h01 ^ seq_cnt;
`else
    cap_chk = 8'h01;
`endif
    for (int unsigned i = 0; i < 4; i++) cap_chk = cap_chk ^ led_in[8*i +: 8];
    for (int unsigned i = 0; i < 5; i++) cap_chk = cap_chk ^ seg_in[8*i +: 8];
  end

  assign trigger = ({led_in, seg_in} != {snap_led, snap_seg}) ||
                   (refresh_cnt == REFRESH_LAST) || pending_force;

  always_ff @(posedge i_clk_50m or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // tx_start is combinational on tx_busy so a trigger at N can strobe at N+1.
  always_comb begin
    state_n     = state;
    frame_start = 1'b0;
    byte_done   = 1'b0;
    frame_done  = 1'b0;
    tx_start_c  = 1'b0;
    case (state)
      IDLE:    if (trigger) begin
                 frame_start = 1'b1;
                 state_n     = SEND;
               end
      SEND:    if (!uart.tx_busy) begin
                 tx_start_c = 1'b1;
                 state_n    = WAIT_HI;
               end
      WAIT_HI: if (uart.tx_busy || (wait_cnt == WAIT_LAST)) state_n = WAIT_LO;
      WAIT_LO: if (!uart.tx_busy) begin
                 if (idx == LAST_IDX) begin
                   frame_done = 1'b1;
                   state_n    = IDLE;
                 end else begin
                   byte_done = 1'b1;
                   state_n   = SEND;
                 end
               end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      snap_led      <= '0;
      snap_seg      <= '0;
      chk           <= '0;
      idx           <= '0;
      wait_cnt      <= '0;
      refresh_cnt   <= '0;
      pending_force <= 1'b0;
      tx_data_q     <= '0;
      report_busy   <= 1'b0;
      frames_sent   <= '0;
`ifdef TWIN_REPORT_SEQ_EN
      seq_cnt       <= '0;
      seq_q         <= '0;
`endif
    end else begin
      pending_force <= (pending_force & ~frame_start) | force_report;
      if (frame_start) begin
        snap_led    <= led_in;
        snap_seg    <= seg_in;
        chk         <= cap_chk;
        idx         <= '0;
        tx_data_q   <= HEADER;
        report_busy <= 1'b1;
        refresh_cnt <= '0;
`ifdef TWIN_REPORT_SEQ_EN
        seq_q       <= seq_cnt;
`endif
      end else if ((state == IDLE) && (refresh_cnt != REFRESH_LAST)) begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end
      if (state == SEND)
        wait_cnt <= '0;
      else if ((state == WAIT_HI) && (wait_cnt != WAIT_LAST))
        wait_cnt <= wait_cnt + WW'(1);
      if (byte_done) begin
        idx       <= next_idx;
        tx_data_q <= next_byte;
      end
      if (frame_done) begin
        report_busy <= 1'b0;
        frames_sent <= frames_sent + 16'd1;
`ifdef TWIN_REPORT_SEQ_EN
        seq_cnt     <= seq_cnt + 8'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_twin_status_reporter.sv
// Scoreboard bench for twin_status_reporter: expected frames queued at stimulus, checked by a tx monitor.
`timescale 1ns/1ps
module tb_twin_status_reporter;

  localparam int unsigned RC  = 50000;
  localparam int unsigned BWM = 4;
`ifdef TWIN_REPORT_SEQ_EN
  localparam int unsigned FL = 13;
`else
  localparam int unsigned FL = 12;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] led_in = '0;
  logic [39:0] seg_in = '0;
  logic        force_report = 1'b0;
  logic        report_busy;
  logic [15:0] frames_sent;

  twin_status_reporter_if uart();

  twin_status_reporter #(.REFRESH_MS(1)) dut (
    .i_clk_50m    (clk),
    .rst_n        (rst_n),
    .led_in       (led_in),
    .seg_in       (seg_in),
    .force_report (force_report),
    .uart         (uart),
    .report_busy  (report_busy),
    .frames_sent  (frames_sent)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0, n_bad = 0;
  logic [FL*8-1:0] exp_q [$];
  int unsigned exp_total = 0, exp_sent = 0, seq_next = 0;
  logic [31:0] last_led = '0;
  logic [39:0] last_seg = '0;

  int unsigned uart_delay = 0, uart_len = 3;
  logic        silent = 1'b0;

  int unsigned mon_idx = 0, frames_seen = 0, last_start_cyc = 0, hdr_cyc = 0;
  logic        prev_start = 1'b0, cur_valid = 1'b0;
  logic [FL*8-1:0] cur_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: header, type, [seq], led MSB first, seg MSB first, XOR of everything but header.
  task automatic push_frame(input logic [31:0] led, input logic [39:0] seg);
    logic [7:0] b [FL];
    logic [FL*8-1:0] f;
    int unsigned k = 2;
    b[0] = 8'hA5;
    b[1] = 8'h01;
`ifdef TWIN_REPORT_SEQ_EN
    b[2] = 8'(seq_next % 256);
    k = 3;
`endif
    for (int i = 0; i < 4; i++) b[k + i]     = 8'(led >> (24 - 8*i));
    for (int i = 0; i < 5; i++) b[k + 4 + i] = 8'(seg >> (32 - 8*i));
    b[FL-1] = 8'h00;
    for (int i = 1; i < FL - 1; i++) b[FL-1] = b[FL-1] ^ b[i];
    for (int i = 0; i < FL; i++) f[(FL-1-i)*8 +: 8] = b[i];
    exp_q.push_back(f);
    exp_total++;
    exp_sent++;
    seq_next++;
    last_led = led;
    last_seg = seg;
  endtask

  // UART transmitter model: optional delay, then busy for uart_len cycles per byte.
  initial begin
    uart.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && uart.tx_start && !silent) begin
        @(posedge clk);
        repeat (uart_delay) @(posedge clk);
        #1 uart.tx_busy = 1'b1;
        repeat (uart_len) @(posedge clk);
        #1 uart.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: pops one expected frame per header and checks each transmitted byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_idx    = 0;
      prev_start = 1'b0;
    end else begin
      if (uart.tx_start) begin
        check("tx_start_while_busy", 32'(uart.tx_busy), 32'd0);
        check("tx_start_back_to_back", 32'(prev_start), 32'd0);
        if (silent && mon_idx != 0)
          check("silent_byte_gap", cyc - last_start_cyc, BWM + 2);
        if (mon_idx == 0) begin
          hdr_cyc = cyc;
          if (exp_q.size() == 0) begin
            cur_valid = 1'b0;
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got header %0h expected no frame", uart.tx_data);
          end else begin
            cur_exp   = exp_q.pop_front();
            cur_valid = 1'b1;
          end
        end
        if (cur_valid)
          check($sformatf("frame%0d_byte%0d", frames_seen, mon_idx),
                32'(uart.tx_data), 32'(cur_exp[(FL-1-mon_idx)*8 +: 8]));
        last_start_cyc = cyc;
        mon_idx++;
        if (mon_idx == FL) begin
          mon_idx = 0;
          frames_seen++;
        end
      end
      prev_start = uart.tx_start;
    end
  end

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (!(frames_seen >= exp_total && !report_busy && exp_q.size() == 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d frames expected %0d", name, frames_seen, exp_total);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_byte(input int unsigned target);
    int unsigned n = 0;
    while (mon_idx < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_byte_timeout: got index %0d expected %0d", mon_idx, target);
    end
  endtask

  task automatic pulse_force();
    @(posedge clk); #1 force_report = 1'b1;
    @(posedge clk); #1 force_report = 1'b0;
  endtask

  task automatic check_sent(input string name);
    check(name, 32'(frames_sent), exp_sent & 32'hFFFF);
  endtask

  initial begin
    int unsigned rel_cyc, drv_cyc, choice;
    logic [31:0] r_led, r_tmp;
    logic [39:0] r_seg;

    #35;
    check("reset_tx_start", 32'(uart.tx_start), 32'd0);
    check("reset_tx_data", 32'(uart.tx_data), 32'd0);
    check("reset_report_busy", 32'(report_busy), 32'd0);
    check("reset_frames_sent", 32'(frames_sent), 32'd0);

    // Periodic refresh with unchanged all-zero state.
    push_frame('0, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    rel_cyc = cyc;
    wait_done("refresh", RC + 2000);
    check("refresh_latency", hdr_cyc - rel_cyc, RC);
    check_sent("frames_after_refresh");

    // State change: strobe on the cycle after the trigger.
    @(posedge clk); #1 led_in = 32'h12345678;
    drv_cyc = cyc;
    push_frame(32'h12345678, '0);
    wait_done("change", 2000);
    check("change_latency", hdr_cyc - drv_cyc, 32'd1);
    check_sent("frames_after_change");

    // Change during byte 3: frame in flight keeps the old value, then a second frame follows.
    @(posedge clk); #1 led_in = 32'hAAAA5555; seg_in = 40'h0102030405;
    push_frame(32'hAAAA5555, 40'h0102030405);
    wait_byte(4);
    @(posedge clk); #1 led_in = 32'hFFFFFFFF;
    push_frame(32'hFFFFFFFF, 40'h0102030405);
    wait_done("midframe", 4000);
    check_sent("frames_after_midframe");

    // Two forces in one frame give exactly one extra frame.
    @(posedge clk); #1 led_in = 32'hC0FFEE00;
    push_frame(32'hC0FFEE00, 40'h0102030405);
    wait_byte(1);
    pulse_force();
    repeat (5) @(posedge clk);
    pulse_force();
    push_frame(32'hC0FFEE00, 40'h0102030405);
    wait_done("force_busy", 4000);
    check_sent("frames_after_force");

    // Transmitter that never asserts busy: bytes advance on the wait timeout.
    silent = 1'b1;
    pulse_force();
    push_frame(last_led, last_seg);
    wait_done("silent", 2000);
    silent = 1'b0;
    check_sent("frames_after_silent");

    // Randomised changes, forces and transmitter timing.
    for (int it = 0; it < 10; it++) begin
      uart_delay = $urandom_range(0, 2);
      uart_len   = $urandom_range(1, 5);
      choice     = $urandom_range(0, 3);
      if (choice == 0) begin
        pulse_force();
        push_frame(last_led, last_seg);
      end else begin
        r_led = $urandom();
        r_tmp = $urandom();
        r_seg = {r_tmp[7:0], 32'($urandom())};
        @(posedge clk); #1 led_in = r_led; seg_in = r_seg;
        if ({r_led, r_seg} != {last_led, last_seg}) push_frame(r_led, r_seg);
      end
      wait_done("random", 3000);
      check_sent($sformatf("frames_random%0d", it));
    end

    // Reset at byte 6 abandons the frame; the next frame restarts from the header.
    uart_delay = 0;
    uart_len   = 3;
    @(posedge clk); #1 led_in = 32'h0BADF00D;
    push_frame(32'h0BADF00D, seg_in);
    wait_byte(6);
    rst_n = 1'b0;
    #1;
    check("abort_tx_start", 32'(uart.tx_start), 32'd0);
    check("abort_report_busy", 32'(report_busy), 32'd0);
    check("abort_frames_sent", 32'(frames_sent), 32'd0);
    exp_total--;
    exp_sent = 0;
    seq_next = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push_frame(32'h0BADF00D, seg_in);
    wait_done("after_abort", 3000);
    check_sent("frames_after_abort");
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
